bin2bcd: RTL and testbench

BIN2BCD -- requirements
Module: bin2bcd

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin2bcd.sv | 119 +++++++++++
 tb/tb_bin2bcd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants and state encoding for the bin2bcd converter.
package bin2bcd_pkg;

  localparam int W_DEF      = 14;
  localparam int DIGITS_DEF = 4;
  localparam int STEPS      = 14;

  // Saturation limit used when BIN2BCD_OVF_EN is defined
  localparam int          SAT_DEC = 9999;
  localparam logic [15:0] SAT_BCD = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock).
// Define BIN2BCD_OVF_EN to saturate inputs above 9999 and add the ovf output.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
`ifdef BIN2BCD_OVF_EN
  output logic         ovf,
`endif
  output logic [15:0]  bcd
);

  state_e              state_q, state_d;
  logic [W-1:0]        sr_q, sr_d;
  logic [4*DIGITS-1:0] acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                done_q, done_d;
  logic [11:0]         adj_low;
`ifdef BIN2BCD_OVF_EN
  logic                ovf_in_q, ovf_in_d;
  logic                ovf_q, ovf_d;
`endif

  // The thousands digit is never corrected, so it shifts as plain binary
  for (genvar g = 0; g < 3; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (adj_low[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_OVF_EN
    ovf_in_d = ovf_in_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BIN2BCD_OVF_EN
          ovf_in_d = (bin > W'(SAT_DEC));
`endif
        end
      end
      SHIFT: begin
        acc_d = {acc_q[14:12], adj_low, sr_q[W-1]};
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef BIN2BCD_OVF_EN
        bcd_d = ovf_in_q ? SAT_BCD : acc_q;
        ovf_d = ovf_in_q;
`else
        bcd_d = acc_q;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_OVF_EN
      ovf_in_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef BIN2BCD_OVF_EN
      ovf_in_q <= ovf_in_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN2BCD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd.sv
// Randomized self-checking bench for bin2bcd against an arithmetic decimal model.
// Build with BIN2BCD_OVF_EN defined to exercise the saturating variant.
module tb_bin2bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
`ifdef BIN2BCD_OVF_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin2bcd #(.W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef BIN2BCD_OVF_EN
    .ovf   (ovf),
`endif
    .bcd   (bcd)
  );

  function automatic logic [15:0] ref_bcd(input int v);
    int th;
`ifdef BIN2BCD_OVF_EN
    if (v > 9999) return 16'h9999;
`endif
    th = (v / 1000) % 16;
    return 16'((th << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic ref_ovf(input int v);
`ifdef BIN2BCD_OVF_EN
    return (v > 9999);
`else
    return 1'b0;
`endif
  endfunction

  // Leaves the bench one negedge after the accepting edge (cycle n = 1)
  task automatic launch(input int v);
    start = 1'b1;
    bin   = 14'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  // Returns at the negedge where done is seen, so a caller may chain a start
  task automatic expect_conv(input int v, input string tag);
    int          n;
    bit          busy_ok;
    bit          hold_ok;
    logic [15:0] prev;
    logic [15:0] exp_b;
    exp_b   = ref_bcd(v);
    n       = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    prev    = bcd;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== (n <= 14)) busy_ok = 1'b0;
      if (bcd !== prev) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("[TB] FAIL %s latency: got %0d cycles, want 16", tag, n);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_bad++;
      $display("[TB] FAIL %s busy_window: got wrong busy profile, want 14 cycles high", tag);
    end
    n_cmp++;
    if (!hold_ok) begin
      n_bad++;
      $display("[TB] FAIL %s bcd_hold: bcd changed mid-conversion, want %h held", tag, prev);
    end
    n_cmp++;
    if (bcd !== exp_b || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL %s bcd(v=%0d): got %h busy=%b, want %h busy=0", tag, v, bcd, busy, exp_b);
    end
`ifdef BIN2BCD_OVF_EN
    n_cmp++;
    if (ovf !== ref_ovf(v)) begin
      n_bad++;
      $display("[TB] FAIL %s ovf(v=%0d): got %b, want %b", tag, v, ovf, ref_ovf(v));
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b bcd=%h, want 0 0 0000", busy, done, bcd);
    end
`ifdef BIN2BCD_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_ovf: got %b, want 0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    launch(1234);
    expect_conv(1234, "single_1234");
  endtask

  task automatic test_back_to_back();
    launch(0);
    expect_conv(0, "b2b_0");
    launch(9999);
    expect_conv(9999, "b2b_9999");
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    int done_n;
    done_cnt = 0;
    done_n   = 0;
    launch(42);
    for (int n = 1; n <= 30; n++) begin
      if (n == 3 || n == 10) begin
        start = 1'b1;
        bin   = 14'd7777;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_n = n;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (done_cnt != 1 || done_n != 16) begin
      n_bad++;
      $display("[TB] FAIL ignore_start_done: got %0d pulses last at %0d, want 1 at 16", done_cnt, done_n);
    end
    n_cmp++;
    if (bcd !== 16'h0042) begin
      n_bad++;
      $display("[TB] FAIL ignore_start_bcd: got %h, want 0042", bcd);
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 16383));
      if (i < 2) v = int'($urandom_range(0, 9999));
      launch(v);
      expect_conv(v, "random");
    end
  endtask

  task automatic test_overflow();
    launch(12345);
    expect_conv(12345, "ovf_12345");
    launch(9999);
    expect_conv(9999, "ovf_9999");
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    launch(5678);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 14'd3;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bcd !== 16'h0000 || done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid: got busy=%b bcd=%h done=%b, want 0 0000 0", busy, bcd, done);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_start_ignored: got busy=%b, want 0", busy);
    end
    for (int n = 0; n < 30; n++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt != 0 || bcd !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL reset_no_done: got %0d pulses bcd=%h, want 0 pulses 0000", done_cnt, bcd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
